// File: rtl/img_proc_pkg.sv
// Shared constants and helpers for the binary image-processing pipeline.
// Downstream stages use WIN3X3_LAT to align their side signals with the 3x3 window.
package img_proc_pkg;

    localparam int H_ACT_DEF  = 1280;
    localparam int WIN3X3_LAT = 2;

    // Smallest address width whose range covers 'depth' entries.
    function automatic int addr_w_for(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) w++;
        return w;
    endfunction

endpackage

// File: rtl/bin_line_ram.sv
// 1-bit single-port line buffer with read-before-write at one address per cycle.
// The old word is presented combinationally and captured by the caller's pipeline register.
module bin_line_ram
    import img_proc_pkg::*;
#(
    parameter int DEPTH  = H_ACT_DEF,
    parameter int ADDR_W = addr_w_for(DEPTH)
) (
    input  logic              video_clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic              din,
    output logic              rdata
);

    logic mem [DEPTH];

    assign rdata = mem[addr];

    always_ff @(posedge video_clk) begin
        if (we) mem[addr] <= din;
    end

endmodule

// File: rtl/bin_win3x3_gen.sv
// 3x3 binary neighbourhood window generator, 2 clk latency, top/left zero padding.
// Define BIN_WIN_EDGE_REPLICATE_EN to replicate the nearest in-image pixel instead of padding.
module bin_win3x3_gen
    import img_proc_pkg::*;
#(
    parameter int H_ACT  = H_ACT_DEF,
    parameter int ADDR_W = addr_w_for(H_ACT)
) (
    input  logic video_clk,
    input  logic rst_n,
    input  logic in_vs,
    input  logic in_de,
    input  logic in_bit,
    output logic win_vs,
    output logic win_de,
    output logic win_11,
    output logic win_12,
    output logic win_13,
    output logic win_21,
    output logic win_22,
    output logic win_23,
    output logic win_31,
    output logic win_32,
    output logic win_33
);

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(H_ACT - 1);

    logic              vs_prev, de_d1, vs_d1, cur_d1, rd0_r, rd1_r;
    logic [ADDR_W-1:0] col_cnt, addr;
    logic [1:0]        line_cnt, line_eff;
    logic              col_ovf, ovf_eff, vs_rise, de_fall, lb_we;
    logic              lb0_rd, lb1_rd, row1_ok, row2_ok, r0_new, r1_new, first_px;
    // Column registers per row, packed as {x1, x2, x3}.
    logic [2:0]        top_q, mid_q, bot_q;

    // A frame start on a pixel cycle restarts that pixel at column 0 of line 0.
    assign vs_rise  = in_vs & ~vs_prev;
    assign de_fall  = ~in_de & de_d1;
    assign addr     = vs_rise ? '0 : col_cnt;
    assign line_eff = vs_rise ? 2'd0 : line_cnt;
    assign ovf_eff  = col_ovf & ~vs_rise;
    assign lb_we    = in_de & ~ovf_eff;
    assign row1_ok  = (line_eff != 2'd0);
    assign row2_ok  = (line_eff == 2'd2);

`ifdef BIN_WIN_EDGE_REPLICATE_EN
    assign r0_new = row1_ok ? lb0_rd : in_bit;
    assign r1_new = row2_ok ? lb1_rd : r0_new;
`else
    assign r0_new = row1_ok & lb0_rd;
    assign r1_new = row2_ok & lb1_rd;
`endif

    bin_line_ram #(.DEPTH(H_ACT), .ADDR_W(ADDR_W)) lb0 (
        .video_clk (video_clk),
        .we        (lb_we),
        .addr      (addr),
        .din       (in_bit),
        .rdata     (lb0_rd)
    );

    // lb1 receives lb0's outgoing word, so it always holds the line before lb0's.
    bin_line_ram #(.DEPTH(H_ACT), .ADDR_W(ADDR_W)) lb1 (
        .video_clk (video_clk),
        .we        (lb_we),
        .addr      (addr),
        .din       (lb0_rd),
        .rdata     (lb1_rd)
    );

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_prev  <= 1'b0;
            col_cnt  <= '0;
            col_ovf  <= 1'b0;
            line_cnt <= 2'd0;
        end else begin
            vs_prev <= in_vs;
            if (in_de) begin
                col_cnt  <= (addr == COL_LAST) ? COL_LAST : addr + ADDR_W'(1);
                col_ovf  <= ovf_eff | (addr == COL_LAST);
                line_cnt <= line_eff;
            end else if (vs_rise) begin
                col_cnt  <= '0;
                col_ovf  <= 1'b0;
                line_cnt <= 2'd0;
            end else if (de_fall) begin
                col_cnt  <= '0;
                col_ovf  <= 1'b0;
                line_cnt <= (line_cnt == 2'd2) ? 2'd2 : line_cnt + 2'd1;
            end
        end
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_d1  <= 1'b0;
            vs_d1  <= 1'b0;
            cur_d1 <= 1'b0;
            rd0_r  <= 1'b0;
            rd1_r  <= 1'b0;
        end else begin
            de_d1  <= in_de;
            vs_d1  <= in_vs;
            cur_d1 <= in_bit;
            rd0_r  <= r0_new;
            rd1_r  <= r1_new;
        end
    end

    // Taps are meaningful only while win_de=1 and hold their value otherwise.
    assign first_px = de_d1 & ~win_de;

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            win_vs <= 1'b0;
            win_de <= 1'b0;
            top_q  <= 3'b000;
            mid_q  <= 3'b000;
            bot_q  <= 3'b000;
        end else begin
            win_vs <= vs_d1;
            win_de <= de_d1;
            if (first_px) begin
`ifdef BIN_WIN_EDGE_REPLICATE_EN
                top_q <= {3{rd1_r}};
                mid_q <= {3{rd0_r}};
                bot_q <= {3{cur_d1}};
`else
                top_q <= {2'b00, rd1_r};
                mid_q <= {2'b00, rd0_r};
                bot_q <= {2'b00, cur_d1};
`endif
            end else if (de_d1) begin
                top_q <= {top_q[1:0], rd1_r};
                mid_q <= {mid_q[1:0], rd0_r};
                bot_q <= {bot_q[1:0], cur_d1};
            end
        end
    end

    assign win_11 = top_q[2];
    assign win_12 = top_q[1];
    assign win_13 = top_q[0];
    assign win_21 = mid_q[2];
    assign win_22 = mid_q[1];
    assign win_23 = mid_q[0];
    assign win_31 = bot_q[2];
    assign win_32 = bot_q[1];
    assign win_33 = bot_q[0];

endmodule

// File: tb/tb_bin_win3x3_gen.sv
// Directed bench for bin_win3x3_gen (H_ACT=8): reference-image window model, de/vs lag tracking.
// Builds with or without BIN_WIN_EDGE_REPLICATE_EN; the pixel model follows the same macro.
`timescale 1ns/1ps
module tb_bin_win3x3_gen;
    import img_proc_pkg::*;

    localparam int HA   = 8;
    localparam int AW   = 3;
    localparam int MAXR = 6;
    localparam int MAXC = 12;

    logic video_clk = 1'b0;
    logic rst_n     = 1'b0;
    logic in_vs     = 1'b0;
    logic in_de     = 1'b0;
    logic in_bit    = 1'b0;
    logic win_vs, win_de;
    logic win_11, win_12, win_13, win_21, win_22, win_23, win_31, win_32, win_33;
    logic [8:0] taps;

    int checks   = 0;
    int failures = 0;

    // bit 9: compare this window; bits 8:0: {w11,w12,w13,w21,w22,w23,w31,w32,w33}
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    logic [8:0] last_win = '0;
    logic       img [MAXR][MAXC];
    logic [WIN3X3_LAT-1:0] de_hist, vs_hist;

    // ---------------- clock / reset ----------------
    always #5 video_clk = ~video_clk;

    bin_win3x3_gen #(.H_ACT(HA), .ADDR_W(AW)) dut (
        .video_clk (video_clk),
        .rst_n     (rst_n),
        .in_vs     (in_vs),
        .in_de     (in_de),
        .in_bit    (in_bit),
        .win_vs    (win_vs),
        .win_de    (win_de),
        .win_11    (win_11),
        .win_12    (win_12),
        .win_13    (win_13),
        .win_21    (win_21),
        .win_22    (win_22),
        .win_23    (win_23),
        .win_31    (win_31),
        .win_32    (win_32),
        .win_33    (win_33)
    );

    assign taps = {win_11, win_12, win_13, win_21, win_22, win_23, win_31, win_32, win_33};

    // ---------------- check helpers ----------------
    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic px(input int r, input int c);
`ifdef BIN_WIN_EDGE_REPLICATE_EN
        return img[(r < 0) ? 0 : r][(c < 0) ? 0 : c];
`else
        if (r < 0 || c < 0) return 1'b0;
        return img[r][c];
`endif
    endfunction

    function automatic logic [8:0] win_exp(input int r, input int c);
        return {px(r-2, c-2), px(r-2, c-1), px(r-2, c),
                px(r-1, c-2), px(r-1, c-1), px(r-1, c),
                px(r,   c-2), px(r,   c-1), px(r,   c)};
    endfunction

    // Expected input history, cleared by reset like the DUT.
    always @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            de_hist <= '0;
            vs_hist <= '0;
        end else begin
            de_hist <= {de_hist[WIN3X3_LAT-2:0], in_de};
            vs_hist <= {vs_hist[WIN3X3_LAT-2:0], in_vs};
        end
    end

    // ---------------- scoreboard ----------------
    always @(negedge video_clk) begin
        if (rst_n) begin
            check1("win_de_lag", win_de, de_hist[WIN3X3_LAT-1]);
            check1("win_vs_lag", win_vs, vs_hist[WIN3X3_LAT-1]);
            if (win_de) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL exp_q_underflow observed=win_de=1 expected=no window");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e[9]) begin
                        check9("taps", taps, mon_e[8:0]);
                        last_win = mon_e[8:0];
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_frame();
        @(posedge video_clk); #1;
        in_vs = 1'b1;
        repeat (2) @(posedge video_clk);
        #1;
        in_vs = 1'b0;
        repeat (2) @(posedge video_clk);
    endtask

    task automatic drive_px(input int r, input int c, input logic b);
        @(posedge video_clk); #1;
        in_de  = 1'b1;
        in_bit = b;
        img[r][c] = b;
        exp_q.push_back({(c < HA) ? 1'b1 : 1'b0, win_exp(r, c)});
    endtask

    task automatic drive_line(input int r, input int n, input logic [MAXC-1:0] bits);
        for (int c = 0; c < n; c++) drive_px(r, c, bits[c]);
        @(posedge video_clk); #1;
        in_de  = 1'b0;
        in_bit = 1'b0;
        repeat (3) @(posedge video_clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        repeat (3) @(posedge video_clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: everything stays low.
        for (int i = 0; i < 4; i++) begin
            @(negedge video_clk);
            check1("idle_win_de", win_de, 1'b0);
            check1("idle_win_vs", win_vs, 1'b0);
            check9("idle_taps", taps, 9'h000);
        end

        // Frame A: three lines of all ones.
        start_frame();
        for (int r = 0; r < 3; r++) drive_line(r, HA, 12'hFFF);
        @(negedge video_clk);
        check9("hold_taps", taps, 9'h1FF);
        check9("hold_model", taps, last_win);

        // Frame B: a single 1 at row 1, column 3.
        start_frame();
        drive_line(0, HA, 12'h000);
        drive_line(1, HA, 12'h008);
        drive_line(2, HA, 12'h000);
        drive_line(3, HA, 12'h000);

        // Frame C: 10-pixel line on an 8-deep buffer; pixels 8/9 must not wrap onto 0/1.
        start_frame();
        drive_line(0, 10, 12'h3A4);
        drive_line(1, HA, 12'h0C3);
        drive_line(2, HA, 12'h05A);

        // Frame D: reset asserted in the middle of line 2.
        start_frame();
        drive_line(0, HA, 12'h0F0);
        drive_line(1, HA, 12'h03C);
        for (int c = 0; c < 4; c++) drive_px(2, c, 1'b1);
        @(posedge video_clk); #1;
        rst_n = 1'b0;
        in_de = 1'b0;
        in_bit = 1'b0;
        exp_q.delete();
        #1;
        check1("rst_mid_win_de", win_de, 1'b0);
        check1("rst_mid_win_vs", win_vs, 1'b0);
        check9("rst_mid_taps", taps, 9'h000);
        repeat (2) @(posedge video_clk);
        #1;
        rst_n = 1'b1;

        // Frame E after reset: top rows must be padded again.
        start_frame();
        drive_line(0, HA, 12'h0AA);
        drive_line(1, HA, 12'h055);
        drive_line(2, HA, 12'h0FF);

        repeat (4) @(posedge video_clk);
        @(negedge video_clk);
        check_int("exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
